// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encodings, master ids and the
// tie-break helper used by the grant decision.
package mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'b00;
    localparam arb_state_t ST_OWN0 = 2'b01;
    localparam arb_state_t ST_OWN1 = 2'b10;
    localparam arb_state_t ST_TURN = 2'b11;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Winner among the requesters; on a tie the master that did not own last wins.
    function automatic logic pick_master(input logic req0, input logic req1, input logic last);
        logic win;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = M1;
        end else begin
            win = M0;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_hold_timer.sv
// 8-bit saturating hold counter with synchronous clear, count enable and a
// limit compare. expire_o looks at the count including the current cycle,
// so it is high in the last permitted cycle and the owner loses the bus at
// the edge where the count reaches limit_i.
module mem_arbiter_hold_timer (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_inc;

    // Saturating increment and next-count selection.
    always_comb begin
        cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
        expire_o = en_i && !clr_i && (cnt_inc >= limit_i);
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory bus arbiter: round-robin grant with one idle turnaround
// cycle between owners, hold watchdog, and a zero-latency bus mux selected
// by the registered grant state.
//
// state | meaning
// IDLE  | no owner, arbitrate on current requests
// OWN0  | master 0 owns the bus
// OWN1  | master 1 owns the bus
// TURN  | one dead cycle after a release/revoke, then arbitrate like IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int W        = 9,
    parameter int HOLD_MAX = 63
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Req0,
    input  logic         Req1,
    input  logic [W-1:0] ADDR0,
    input  logic [W-1:0] ADDR1,
    input  logic [W-1:0] DOUT0,
    input  logic [W-1:0] DOUT1,
    input  logic         Write0,
    input  logic         Write1,
    output logic         Gnt0,
    output logic         Gnt1,
    output logic [W-1:0] MemADDR,
    output logic [W-1:0] MemDOUT,
    output logic         MemWrite,
    output logic         Timeout,
    output logic         TimeoutId
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;
    logic       last_d;
    logic       timeout_q;
    logic       timeout_d;
    logic       tid_q;
    logic       tid_d;
    logic       own;
    logic       expire;
    logic       win;

    assign own = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign win = pick_master(Req0, Req1, last_q);

    // Counter is held clear outside ownership so every grant starts from zero.
    mem_arbiter_hold_timer u_hold_timer (
        .clk_i    (Clock),
        .rst_n_i  (Resetn),
        .clr_i    (!own),
        .en_i     (own),
        .limit_i  (HOLD_LIM),
        .expire_o (expire)
    );

    // Next-state, round-robin memory and watchdog decisions.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        tid_d     = tid_q;
        case (state_q)
            ST_OWN0: begin
                if (!Req0) begin
                    state_d = ST_TURN;
                    last_d  = M0;
                end else if (expire) begin
                    state_d   = ST_TURN;
                    last_d    = M0;
                    timeout_d = 1'b1;
                    tid_d     = M0;
                end
            end
            ST_OWN1: begin
                if (!Req1) begin
                    state_d = ST_TURN;
                    last_d  = M1;
                end else if (expire) begin
                    state_d   = ST_TURN;
                    last_d    = M1;
                    timeout_d = 1'b1;
                    tid_d     = M1;
                end
            end
            default: begin
                if (Req0 || Req1) begin
                    state_d = (win == M1) ? ST_OWN1 : ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers; last resets to master 1 so master 0 wins the first tie.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            last_q    <= M1;
            timeout_q <= 1'b0;
            tid_q     <= M0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            tid_q     <= tid_d;
        end
    end

    // Bus mux: owner's lines pass straight through, otherwise the bus is quiet.
    always_comb begin
        MemADDR  = '0;
        MemDOUT  = '0;
        MemWrite = 1'b0;
        case (state_q)
            ST_OWN0: begin
                MemADDR  = ADDR0;
                MemDOUT  = DOUT0;
                MemWrite = Write0;
            end
            ST_OWN1: begin
                MemADDR  = ADDR1;
                MemDOUT  = DOUT1;
                MemWrite = Write1;
            end
            default: begin
                MemADDR  = '0;
                MemDOUT  = '0;
                MemWrite = 1'b0;
            end
        endcase
    end

    assign Gnt0      = (state_q == ST_OWN0);
    assign Gnt1      = (state_q == ST_OWN1);
    assign Timeout   = timeout_q;
    assign TimeoutId = tid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a bus-ownership model checked every cycle, plus
// hand-computed literal expectations at the key points of each scenario.
module tb_mem_arbiter;

    localparam int W    = 9;
    localparam int HOLD = 4;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         Req0, Req1;
    logic [W-1:0] ADDR0, ADDR1, DOUT0, DOUT1;
    logic         Write0, Write1;
    logic         Gnt0, Gnt1;
    logic [W-1:0] MemADDR, MemDOUT;
    logic         MemWrite, Timeout, TimeoutId;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // Model: who owns the bus, for how many edges, and who owned it last.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 1;
    bit m_to    = 1'b0;
    bit m_tid   = 1'b0;

    mem_arbiter #(.W(W), .HOLD_MAX(HOLD)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .Req0(Req0), .Req1(Req1),
        .ADDR0(ADDR0), .ADDR1(ADDR1),
        .DOUT0(DOUT0), .DOUT1(DOUT1),
        .Write0(Write0), .Write1(Write1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .MemADDR(MemADDR), .MemDOUT(MemDOUT), .MemWrite(MemWrite),
        .Timeout(Timeout), .TimeoutId(TimeoutId)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        bit req;
        if (!Resetn) begin
            m_owner = -1; m_held = 0; m_last = 1; m_to = 1'b0; m_tid = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                m_held = m_held + 1;
                req = (m_owner == 1) ? Req1 : Req0;
                if (!req) begin
                    m_last = m_owner; m_owner = -1;
                end else if (m_held >= HOLD) begin
                    m_last = m_owner; m_to = 1'b1; m_tid = (m_owner == 1);
                    m_owner = -1;
                end
            end else begin
                m_held = 0;
                if (Req0 && Req1)  m_owner = (m_last == 1) ? 0 : 1;
                else if (Req0)     m_owner = 0;
                else if (Req1)     m_owner = 1;
            end
            chk_en = 1'b1;
        end
    end

    always @(negedge Clock) begin
        logic [2*W+4:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = {m_owner == 0, m_owner == 1,
                     (m_owner == 0) ? ADDR0 : (m_owner == 1) ? ADDR1 : 9'h000,
                     (m_owner == 0) ? DOUT0 : (m_owner == 1) ? DOUT1 : 9'h000,
                     (m_owner == 0) ? Write0 : (m_owner == 1) ? Write1 : 1'b0,
                     m_to, m_tid};
            act_v = {Gnt0, Gnt1, MemADDR, MemDOUT, MemWrite, Timeout, TimeoutId};
            n_vec++;
            if (act_v !== exp_v) begin
                n_miss++;
                $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #2;
        end
    endtask

    logic [1:0] pat [16] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11,
                             2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00};

    initial begin
        Resetn = 1'b0; Req0 = 0; Req1 = 0;
        ADDR0 = '0; ADDR1 = '0; DOUT0 = '0; DOUT1 = '0; Write0 = 0; Write1 = 0;
        cyc(2);
        check("rst_gnt", {Gnt0, Gnt1}, 0);
        check("rst_mem", {MemADDR, MemDOUT, MemWrite}, 0);
        check("rst_to", {Timeout, TimeoutId}, 0);

        // Master 0 alone, write passes through in the grant cycle.
        Resetn = 1'b1; Req0 = 1; ADDR0 = 9'h01A; DOUT0 = 9'h055; Write0 = 1;
        cyc(1);
        check("solo_gnt0", {Gnt0, Gnt1}, 2'b10);
        check("solo_addr", MemADDR, 9'h01A);
        check("solo_wr", MemWrite, 1);
        ADDR0 = 9'h033; #1;
        check("mux_zero_lat", MemADDR, 9'h033);
        cyc(1);
        Req0 = 0;
        cyc(1);
        check("release_turn", {Gnt0, Gnt1, MemADDR, MemWrite}, 0);

        // Tie after reset: master 0 first, non-owner write ignored.
        Resetn = 1'b0; cyc(1);
        Resetn = 1'b1; Req0 = 1; Req1 = 1; Write0 = 0; ADDR0 = 9'h02A;
        cyc(1);
        check("tie_gnt0", {Gnt0, Gnt1}, 2'b10);
        Write1 = 1; ADDR1 = 9'h1FF; DOUT1 = 9'h0C3; #1;
        check("nonowner_wr", MemWrite, 0);
        check("nonowner_addr", MemADDR, 9'h02A);
        Write0 = 1; #1;
        check("owner_wr", MemWrite, 1);
        cyc(1);
        Req0 = 0;
        cyc(1);
        check("tie_turn", {Gnt0, Gnt1, MemADDR, MemDOUT, MemWrite}, 0);
        cyc(1);
        check("tie_gnt1", {Gnt0, Gnt1}, 2'b01);
        check("gnt1_bus", {MemADDR, MemWrite}, {9'h1FF, 1'b1});
        Req1 = 0;
        cyc(1);
        Req0 = 1; Req1 = 1;
        cyc(1);
        check("alt_gnt0", {Gnt0, Gnt1}, 2'b10);

        // Watchdog: master 0 held 4 cycles, then revoked, master 1 follows.
        cyc(3);
        check("hold_c4", {Gnt0, Timeout}, 2'b10);
        cyc(1);
        check("wd0_pulse", {Gnt0, Gnt1, Timeout, TimeoutId}, 4'b0010);
        cyc(1);
        check("wd0_after", {Gnt0, Gnt1, Timeout, TimeoutId}, 4'b0100);
        cyc(3);
        check("hold1_c4", {Gnt1, Timeout}, 2'b10);
        cyc(1);
        check("wd1_pulse", {Gnt0, Gnt1, Timeout, TimeoutId}, 4'b0011);
        cyc(1);
        check("revoked_loses_tie", {Gnt0, Gnt1, Timeout, TimeoutId}, 4'b1001);

        // Reset in the middle of an OWN1 write.
        Req0 = 0;
        cyc(1);
        cyc(1);
        check("own1_pre_rst", {Gnt1, MemWrite}, 2'b11);
        Resetn = 1'b0;
        cyc(1);
        check("rst_mid_grant", {Gnt0, Gnt1, MemWrite, TimeoutId}, 0);
        Resetn = 1'b1; Req0 = 1; Req1 = 1;
        cyc(1);
        check("post_rst_tie", {Gnt0, Gnt1}, 2'b10);

        // Request pattern sweep, each pattern held for three cycles.
        for (int i = 0; i < 16; i++) begin
            Req0 = pat[i][0]; Req1 = pat[i][1];
            ADDR0 = 9'(i * 7); ADDR1 = 9'(i * 13 + 1);
            DOUT0 = 9'(i + 100); DOUT1 = 9'(300 - i);
            Write0 = i[0]; Write1 = i[1];
            cyc(3);
        end
        Req0 = 0; Req1 = 0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single 9-bit synchronous SRAM/IO address space between the processor (master 0) and a second bus master (master 1: loader/DMA or second core). It grants the memory bus with a req/gnt handshake, alternates priority round-robin, and inserts one idle turnaround cycle between owners. A hold watchdog forcibly reclaims the bus from a stuck master. Master address/data/write lines reach the memory through a combinational mux selected by a registered grant, so each master sees exactly the memory latency it sees when connected directly.

## Interface
Parameters:
- `W`, 9: address and data width.
- `HOLD_MAX`, 63: maximum consecutive granted cycles before the watchdog revokes the grant; legal range 1..255.

Ports:
- `Clock`  in  1  system clock; all state changes on posedge.
- `Resetn`  in  1  reset, synchronous, active-low.
- `Req0`, `Req1`  in  1  bus request from master 0 / master 1; held high for the whole transaction sequence.
- `ADDR0`, `ADDR1`  in  W  master address.
- `DOUT0`, `DOUT1`  in  W  master write data.
- `Write0`, `Write1`  in  1  master write strobe.
- `Gnt0`, `Gnt1`  out  1  registered grant; at most one high.
- `MemADDR`  out  W  address to memory.
- `MemDOUT`  out  W  write data to memory.
- `MemWrite`  out  1  write strobe to memory.
- `Timeout`  out  1  one-cycle pulse when the watchdog revokes a grant.
- `TimeoutId`  out  1  master revoked by the last timeout; holds its value until the next timeout.

## Operation
- States: IDLE, OWN0, OWN1, TURN. Encoding: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10, TURN=2'b11.
- IDLE:
  - Only `Req0` high: go to OWN0.
  - Only `Req1` high: go to OWN1.
  - Both high: grant the master other than `Last`.
  - Neither high: stay in IDLE.
- OWNn: `Gntn`=1. Stay while `Reqn`=1 and the hold counter is below `HOLD_MAX`.
  - `Reqn` drops: go to TURN and set `Last`<=n.
  - Counter reaches `HOLD_MAX` with `Reqn` still high: go to TURN, set `Last`<=n, pulse `Timeout` and set `TimeoutId`<=n in the same cycle.
- TURN: lasts exactly one cycle with no grant, then behaves as IDLE for the next decision. The revoked master's `Req` counts as an ordinary request, but the other master wins a tie.
- Hold counter: 8-bit. Cleared on entry to OWNn, incremented each OWN cycle, saturates, unused outside OWN states.
- Bus mux, combinational:
  - OWN0: Mem* = master-0 lines.
  - OWN1: Mem* = master-1 lines.
  - IDLE/TURN: `MemADDR`=`MemDOUT`=0 and `MemWrite`=0.
- `MemWrite` is forced 0 in every cycle where the selecting grant is not high. A write strobe from a non-owner is ignored.
- Memory read data is not routed through this block. Both masters' `DIN` connect directly to memory output and qualify it with their own grant.

## Timing
- Reset (`Resetn`=0 at posedge): state IDLE, `Last`=1 (master 0 wins the first tie), counter 0. `Gnt0`=`Gnt1`=0, `Timeout`=0, `TimeoutId`=0, Mem* all 0. Reset applies mid-grant with no completion of the in-flight access.
- Grant latency: `Req` sampled high in IDLE at edge k gives `Gnt` high after edge k; Mem* follow the owner from that cycle.
- Release: `Req` low sampled at edge k gives `Gnt` low after edge k, then one TURN cycle. The earliest next grant is visible after edge k+1.
- Mux path is zero-latency: owner `ADDR`/`DOUT`/`Write` changes appear on Mem* in the same cycle.
- Max hold is `HOLD_MAX` cycles. `Gnt` drops after the edge at which the counter equals `HOLD_MAX`, and `Timeout` is high in that following cycle only.
- Simultaneous request at release: the other master wins regardless of `Last` update order.

## Structure
- Header `mem_arbiter_defs.vh` holds the state encodings and master-id constants (`M0`=1'b0, `M1`=1'b1). It is shared with the loader and system top-level.
- Sub-module `hold_timer`: 8-bit saturating counter with sync clear, enable, and a `>= limit` compare output. Its reuse as the core's `Run` watchdog is planned.
- Top-level FSM, `Last` register and mux stay in `mem_arbiter`.

## Test plan
- Reset, then `Req0`=1 alone: `Gnt0`=1 next cycle. With `ADDR0`=9'h01A, `Write0`=1, `MemADDR`=9'h01A and `MemWrite`=1 in the same cycle.
- `Req0` and `Req1` rise together after reset: `Gnt0` first. `Req0` drops, giving one TURN cycle with all Mem*=0, then `Gnt1`. Repeat the tie: `Gnt0` wins again (alternation).
- Non-owner write: master 1 drives `Write1`=1 and `ADDR1`=9'h1FF while master 0 owns. `MemWrite` follows `Write0` only and `MemADDR` equals `ADDR0`.
- `HOLD_MAX`=4, `Req0` held high, `Req1` high: `Gnt0` lasts 4 cycles, then `Timeout` pulses 1 cycle with `TimeoutId`=0. TURN follows, then `Gnt1`.
- `Resetn`=0 during OWN1 with `Write1`=1: after the edge, `Gnt1`=0, `MemWrite`=0, state IDLE. The next tie grants master 0.
- Processor integration: the core runs `mvi R1,#5` and `st R1,[R2]` while owning the bus. Results are identical to a direct SRAM hookup; the store lands at `R2`'s address.
